// File: rtl/elbeth_mem_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
// FSM states, byte-enable width and default geometry.
package elbeth_mem_pkg;

  localparam int BE_W = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/elbeth_mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and one memory port.
// slave = arbiter view, master = environment view.
interface elbeth_mem_arbiter_if
  import elbeth_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  a_enable;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data_in;
  logic [BE_W-1:0]       a_wr;
  logic [DATA_WIDTH-1:0] a_data_out;
  logic                  a_ready;
  logic                  a_err;

  logic                  b_enable;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data_in;
  logic [BE_W-1:0]       b_wr;
  logic [DATA_WIDTH-1:0] b_data_out;
  logic                  b_ready;
  logic                  b_err;

  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [BE_W-1:0]       mem_wr;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_ready;

  logic                  busy;
  logic                  grant;

  modport slave (
    input  a_enable, a_addr, a_data_in, a_wr,
    output a_data_out, a_ready, a_err,
    input  b_enable, b_addr, b_data_in, b_wr,
    output b_data_out, b_ready, b_err,
    output mem_enable, mem_addr, mem_data_in, mem_wr,
    input  mem_data_out, mem_ready,
    output busy, grant
  );

  modport master (
    output a_enable, a_addr, a_data_in, a_wr,
    input  a_data_out, a_ready, a_err,
    output b_enable, b_addr, b_data_in, b_wr,
    input  b_data_out, b_ready, b_err,
    input  mem_enable, mem_addr, mem_data_in, mem_wr,
    output mem_data_out, mem_ready,
    input  busy, grant
  );

endinterface

// File: rtl/elbeth_rr_arbiter.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
// winner: 0 = A (req[0]), 1 = B (req[1]).
module elbeth_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Shares one memory port between requesters A and B.
// IDLE -> WAIT (until mem_ready or timeout) -> RESP -> IDLE.
module elbeth_mem_arbiter
  import elbeth_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  elbeth_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  last;
  logic                  win;
  logic                  done;
  logic                  rd_ok;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [BE_W-1:0]       sel_wr;

  elbeth_rr_arbiter u_rr (
    .req    ({bus.b_enable, bus.a_enable}),
    .last   (last),
    .winner (win)
  );

  assign sel_addr = win ? bus.b_addr    : bus.a_addr;
  assign sel_data = win ? bus.b_data_in : bus.a_data_in;
  assign sel_wr   = win ? bus.b_wr      : bus.a_wr;

  // mem_ready wins over a timeout landing on the same cycle
  assign done  = bus.mem_ready || (cnt == LIM);
  assign rd_ok = bus.mem_ready && (bus.mem_wr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      last            <= 1'b1;
      bus.mem_enable  <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_data_in <= '0;
      bus.mem_wr      <= '0;
      bus.a_ready     <= 1'b0;
      bus.a_err       <= 1'b0;
      bus.a_data_out  <= '0;
      bus.b_ready     <= 1'b0;
      bus.b_err       <= 1'b0;
      bus.b_data_out  <= '0;
      bus.busy        <= 1'b0;
      bus.grant       <= 1'b0;
    end else begin
      bus.a_ready <= 1'b0;
      bus.a_err   <= 1'b0;
      bus.b_ready <= 1'b0;
      bus.b_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.a_enable || bus.b_enable) begin
            bus.mem_addr    <= sel_addr;
            bus.mem_data_in <= sel_data;
            bus.mem_wr      <= sel_wr;
            bus.mem_enable  <= 1'b1;
            bus.grant       <= win;
            bus.busy        <= 1'b1;
            last            <= win;
            cnt             <= '0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            bus.mem_enable <= 1'b0;
            state          <= RESP;
            if (bus.grant) begin
              bus.b_ready <= 1'b1;
              bus.b_err   <= ~bus.mem_ready;
              if (rd_ok) bus.b_data_out <= bus.mem_data_out;
            end else begin
              bus.a_ready <= 1'b1;
              bus.a_err   <= ~bus.mem_ready;
              if (rd_ok) bus.a_data_out <= bus.mem_data_out;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/elbeth_mem_arbiter.md
ELBETH_MEM_ARBITER -- requirements
Module: elbeth_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 8, word address width; DATA_WIDTH, 32, data width; TIMEOUT, 16, max cycles waiting for mem_ready (>=1).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst  in  1  async active-high reset
- a_enable  in  1  requester A request, held until a_ready
- a_addr  in  ADDR_WIDTH  A address
- a_data_in  in  DATA_WIDTH  A write data
- a_wr  in  4  A byte write enables; 0 = read
- a_data_out  out  DATA_WIDTH  A read data
- a_ready  out  1  A completion pulse, one cycle
- a_err  out  1  A timeout flag, valid with a_ready
- b_enable, b_addr, b_data_in, b_wr, b_data_out, b_ready, b_err: same as A, for requester B
- mem_enable  out  1  memory port request
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data_in  out  DATA_WIDTH  memory write data
- mem_wr  out  4  memory byte enables
- mem_data_out  in  DATA_WIDTH  memory read data
- mem_ready  in  1  memory completion
- busy  out  1  high in WAIT or RESP
- grant  out  1  owner of current access: 0 = A, 1 = B

Function
REQ-004 FSM states SHALL be IDLE, WAIT, RESP; all outputs registered.
REQ-005 IDLE: if any x_enable is sampled high, SHALL latch winner's addr/data_in/wr into mem_*, set grant, assert mem_enable, enter WAIT next cycle; else stay IDLE.
REQ-006 Both enables high in IDLE SHALL resolve round-robin: winner is the requester not granted last; A wins first tie after reset.
REQ-007 WAIT: mem_enable, mem_addr, mem_data_in, mem_wr SHALL stay stable until mem_ready is sampled high.
REQ-008 WAIT with mem_ready high SHALL: next cycle deassert mem_enable, pulse owner's x_ready for exactly one cycle with x_err=0, enter RESP.
REQ-009 Read (wr==0) completion SHALL load owner's x_data_out from mem_data_out; write completion SHALL leave x_data_out unchanged.
REQ-010 Timeout counter SHALL clear on entering WAIT and increment each WAIT cycle; reaching TIMEOUT without mem_ready SHALL pulse owner's x_ready with x_err=1, keep x_data_out unchanged, deassert mem_enable, enter RESP.
REQ-011 mem_ready and timeout in the same cycle: mem_ready SHALL take precedence (err=0).
REQ-012 RESP SHALL last one cycle, ignore all requests, then return to IDLE.
REQ-013 Minimum latency: enable sampled cycle N, mem_ready at N+1 -> x_ready at N+2; same requester back-to-back every 3 cycles.
REQ-014 Non-owner's ready/err/data_out SHALL be unaffected by the current access.
REQ-015 Dropping x_enable before x_ready is a protocol violation; the access SHALL still complete and ready pulse.
REQ-016 mem_ready outside WAIT SHALL be ignored.
REQ-017 x_err SHALL be 0 whenever x_ready is 0.

Reset
REQ-018 rst high SHALL force IDLE immediately; mem_enable, mem_addr, mem_data_in, mem_wr, a/b_ready, a/b_err, a/b_data_out, busy, grant all 0; counter 0; last-grant = B.
REQ-019 Reset mid-WAIT SHALL abort the access with no ready pulse; the first request after release restarts from IDLE.

Structure
REQ-020 Package elbeth_mem_pkg SHALL hold the state enumeration, byte-enable width (4) and default ADDR_WIDTH/DATA_WIDTH/TIMEOUT constants.
REQ-021 Two-way round-robin selection SHALL be a sub-module elbeth_rr_arbiter (inputs req[1:0], last; output winner); the rest is in the top.

Verification
REQ-022 A reads addr 0x05, mem_ready one cycle after mem_enable, mem_data_out=0x12345678 -> a_ready at N+2, a_data_out=0x12345678, a_err=0, b outputs unchanged.
REQ-023 A and B both enable in same IDLE cycle after reset -> A granted first, B granted in the next IDLE, grant 0 then 1; repeated ties alternate.
REQ-024 B writes 0xFFFFFFFF, wr=1111, addr 0x02; mem_ready withheld 5 cycles -> mem_* stable 6 cycles, b_ready one cycle, b_data_out unchanged.
REQ-025 mem_ready never asserted, TIMEOUT=16 -> x_ready with x_err=1 after 16 WAIT cycles; mem_ready on cycle 16 -> err=0.
REQ-026 rst pulsed during WAIT -> all outputs 0 asynchronously, no ready pulse; next request served normally.
